// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I decode slot with pause FSM, flush and illegal-opcode counter
module decode_stage #(
    parameter int XLEN      = 32,
    parameter int ERRCNT_W  = 8,
    parameter bit EN_BRANCH = 1'b1,
    parameter bit EN_UPPER  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         instr,
    input  logic [XLEN-1:0]     pc,
    input  logic                flush,
    input  logic                resume,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                memtoreg,
    output logic                memwrite,
    output logic                alusrcimm,
    output logic                writesreg,
    output logic                jump,
    output logic                branch,
    output logic                jalr,
    output logic                pcsrc_a,
    output logic                pause,
    output logic                illegal,
    output logic [3:0]          aluop,
    output logic [2:0]          itype,
    output logic [XLEN-1:0]     imm,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [4:0]          rd,
    output logic [2:0]          funct3,
    output logic [XLEN-1:0]     pc_out,
    output logic                paused,
    output logic [ERRCNT_W-1:0] err_count
);
    localparam logic [2:0] RTYPE = 3'd0, ITYPE = 3'd1, STYPE = 3'd2,
                           BTYPE = 3'd3, UTYPE = 3'd4, JTYPE = 3'd5;
    localparam logic [6:0] OP_IMMALU = 7'b0010011, OP_REGALU = 7'b0110011,
                           OP_LOAD   = 7'b0000011, OP_STORE  = 7'b0100011,
                           OP_JAL    = 7'b1101111, OP_JALR   = 7'b1100111,
                           OP_BRANCH = 7'b1100011, OP_LUI    = 7'b0110111,
                           OP_AUIPC  = 7'b0010111, OP_PAUSE  = 7'b0001111;

    typedef enum logic {ST_RUN, ST_PAUSED} state_t;
    state_t state;

    logic        accept;
    logic        d_memtoreg, d_memwrite, d_alusrcimm, d_writesreg, d_jump;
    logic        d_branch, d_jalr, d_pcsrc_a, d_pause, d_illegal;
    logic [3:0]  d_aluop;
    logic [2:0]  d_itype;
    logic [31:0] d_imm32;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign in_ready = rst_n && (state == ST_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign paused   = (state == ST_PAUSED);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    // Every listed opcode ends in 2'b11, so the full 7-bit match also rejects compressed encodings.
    always_comb begin
        d_memtoreg  = 1'b0;
        d_memwrite  = 1'b0;
        d_alusrcimm = 1'b0;
        d_writesreg = 1'b0;
        d_jump      = 1'b0;
        d_branch    = 1'b0;
        d_jalr      = 1'b0;
        d_pcsrc_a   = 1'b0;
        d_pause     = 1'b0;
        d_illegal   = 1'b0;
        d_aluop     = 4'b0000;
        d_itype     = RTYPE;
        d_imm32     = 32'd0;
        case (instr[6:0])
            OP_IMMALU: begin
                d_alusrcimm = 1'b1;
                d_writesreg = 1'b1;
                d_itype     = ITYPE;
                d_aluop     = (instr[14:12] == 3'b101) ? {instr[30], instr[14:12]}
                                                       : {1'b0, instr[14:12]};
                d_imm32     = imm_i;
            end
            OP_REGALU: begin
                d_writesreg = 1'b1;
                d_aluop     = {instr[30], instr[14:12]};
            end
            OP_LOAD: begin
                d_memtoreg  = 1'b1;
                d_alusrcimm = 1'b1;
                d_writesreg = 1'b1;
                d_itype     = ITYPE;
                d_imm32     = imm_i;
            end
            OP_STORE: begin
                d_memwrite  = 1'b1;
                d_alusrcimm = 1'b1;
                d_itype     = STYPE;
                d_imm32     = imm_s;
            end
            OP_JAL: begin
                d_jump      = 1'b1;
                d_writesreg = 1'b1;
                d_itype     = JTYPE;
                d_imm32     = imm_j;
            end
            OP_JALR: begin
                if (EN_BRANCH) begin
                    d_jump      = 1'b1;
                    d_jalr      = 1'b1;
                    d_alusrcimm = 1'b1;
                    d_writesreg = 1'b1;
                    d_itype     = ITYPE;
                    d_imm32     = imm_i;
                end else begin
                    d_illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (EN_BRANCH) begin
                    d_branch = 1'b1;
                    d_itype  = BTYPE;
                    d_aluop  = 4'b1000;
                    d_imm32  = imm_b;
                end else begin
                    d_illegal = 1'b1;
                end
            end
            OP_LUI, OP_AUIPC: begin
                if (EN_UPPER) begin
                    d_alusrcimm = 1'b1;
                    d_writesreg = 1'b1;
                    d_pcsrc_a   = (instr[6:0] == OP_AUIPC);
                    d_itype     = UTYPE;
                    d_imm32     = imm_u;
                end else begin
                    d_illegal = 1'b1;
                end
            end
            OP_PAUSE: d_pause = 1'b1;
            default:  d_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            out_valid <= 1'b0;
            memtoreg  <= 1'b0;
            memwrite  <= 1'b0;
            alusrcimm <= 1'b0;
            writesreg <= 1'b0;
            jump      <= 1'b0;
            branch    <= 1'b0;
            jalr      <= 1'b0;
            pcsrc_a   <= 1'b0;
            pause     <= 1'b0;
            illegal   <= 1'b0;
            aluop     <= 4'b0000;
            itype     <= RTYPE;
            imm       <= '0;
            rs1       <= 5'd0;
            rs2       <= 5'd0;
            rd        <= 5'd0;
            funct3    <= 3'd0;
            pc_out    <= '0;
            err_count <= '0;
        end else if (flush) begin
            // Flush wins over everything; the held bundle fields are left as-is but invalidated.
            out_valid <= 1'b0;
            state     <= ST_RUN;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                memtoreg  <= d_memtoreg;
                memwrite  <= d_memwrite;
                alusrcimm <= d_alusrcimm;
                writesreg <= d_writesreg;
                jump      <= d_jump;
                branch    <= d_branch;
                jalr      <= d_jalr;
                pcsrc_a   <= d_pcsrc_a;
                pause     <= d_pause;
                illegal   <= d_illegal;
                aluop     <= d_aluop;
                itype     <= d_itype;
                imm       <= XLEN'($signed(d_imm32));
                rs1       <= instr[19:15];
                rs2       <= instr[24:20];
                rd        <= instr[11:7];
                funct3    <= instr[14:12];
                pc_out    <= pc;
                if (d_pause) begin
                    state <= ST_PAUSED;
                end
                if (d_illegal && (err_count != {ERRCNT_W{1'b1}})) begin
                    err_count <= err_count + 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if ((state == ST_PAUSED) && resume) begin
                state <= ST_RUN;
            end
        end
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage for the RISC-V pipeline model. It replaces the purely combinational main decoder with a valid/ready pipeline slot and extends decoding to the full RV32I control-flow and upper-immediate set. It also adds XLEN-wide immediate generation, a PAUSE/resume state machine, flush handling and illegal-opcode detection with a saturating error counter. The stage sits between fetch (upstream) and execute (downstream).

## Interface
- XLEN, 32: datapath and immediate width; must be ≥32.
- ERRCNT_W, 8: width of the illegal-instruction counter.
- EN_BRANCH, 1: when 0, BRANCH (1100011) and JALR (1100111) decode as illegal.
- EN_UPPER, 1: when 0, LUI (0110111) and AUIPC (0010111) decode as illegal.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage accepts this cycle.
- instr  in  32  instruction word.
- pc  in  XLEN  instruction address.
- flush  in  1  drop the held instruction and return to RUN.
- resume  in  1  leave PAUSED.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute consumes the bundle.
- memtoreg, memwrite, alusrcimm, writesreg, jump, branch, jalr, pcsrc_a, pause, illegal  out  1 each  control bits.
- aluop  out  4  ALU operation.
- itype  out  3  format code from the shared format header (RTYPE/ITYPE/STYPE/BTYPE/UTYPE/JTYPE).
- imm  out  XLEN  sign-extended immediate.
- rs1, rs2, rd  out  5 each  raw register fields.
- funct3  out  3  raw funct3.
- pc_out  out  XLEN  registered pc.
- paused  out  1  FSM is in PAUSED.
- err_count  out  ERRCNT_W  saturating count of accepted illegal instructions.

## Operation
- One output register slot; the bundle is loaded from combinational decode of instr on accept.
- accept = in_valid && in_ready && !flush.
- in_ready = rst_n && state==RUN && (!out_valid || out_ready).
- Decode table (unlisted control bits are 0):
  - IMMALU 0010011: alusrcimm, writesreg; ITYPE; aluop={funct7[5],funct3} if funct3==101, else {0,funct3}.
  - REGALU 0110011: writesreg; RTYPE; aluop={funct7[5],funct3}.
  - LOAD 0000011: memtoreg, alusrcimm, writesreg; ITYPE; aluop=0000.
  - STORE 0100011: memwrite, alusrcimm; STYPE; aluop=0000.
  - JAL 1101111: jump, writesreg; JTYPE; aluop=0000.
  - JALR: jump, jalr, alusrcimm, writesreg; ITYPE; aluop=0000.
  - BRANCH: branch; BTYPE; aluop=1000.
  - LUI: alusrcimm, writesreg; UTYPE; aluop=0000.
  - AUIPC: LUI bits plus pcsrc_a.
  - PAUSE 0001111: pause; RTYPE; aluop=0000.
  - Any other opcode, instr[1:0]!=11, or a disabled group: illegal=1, all other control bits 0, aluop=0000, itype=RTYPE. The bundle is still emitted with out_valid=1.
- Immediates, sign-extended to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25],instr[11:7]}.
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - U: {instr[31:12],12'b0}, sign-extended from bit 31.
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - R, PAUSE and illegal: 0.
- FSM states and transitions:
  - RUN → PAUSED on accepting a PAUSE instruction.
  - PAUSED → RUN on resume or flush.
  - resume in RUN is ignored.
  - The pause bundle is still presented and must be drained by out_ready while PAUSED.
- err_count increments on each accepted illegal instruction and saturates at all-ones.

## Timing
- Reset (asynchronous assert, released synchronously to clk): out_valid=0, every control output 0, aluop=0, itype=RTYPE, imm/pc_out/rs1/rs2/rd/funct3=0, state RUN, paused=0, err_count=0, in_ready=0 while rst_n is low.
- Latency: 1 cycle from accept to out_valid.
- Throughput: one instruction per cycle when out_ready is held high.
- out_valid next = accept ? 1 : (out_valid && !out_ready && !flush).
- Bundle fields stay stable while out_valid && !out_ready.
- flush has priority over accept, resume and hold: the next cycle has out_valid=0 and state RUN, and the dropped instruction is not counted.
- Accept and drain in the same cycle: the new bundle replaces the old one with no bubble.
- Reset mid-PAUSED or mid-stall returns everything to the reset values.

## Test plan
- Reset, then hold in_valid with instr 0x00500093 (addi x1,x0,5): one cycle later out_valid=1, alusrcimm=1, writesreg=1, imm=5, rd=1, aluop=0000; err_count=0.
- instr 0x4020D093 (srai x1,x1,2) → aluop=1101, imm=0x402 (shamt field in imm[4:0]=2). Then 0xFE000EE3 (beq x0,x0,-4) → branch=1, aluop=1000, imm=0xFFFFFFFC.
- Back-to-back stream with out_ready low for 3 cycles: in_ready=0 and the bundle is stable for those cycles; when out_ready rises, the next bundle appears the following cycle with no loss or duplication.
- PAUSE (0x0000000F): out_valid=1, pause=1, paused=1 and in_ready=0 until resume is pulsed; one cycle after resume, in_ready=1.
- Stream 300 instructions with opcode 0000000: illegal=1 on each and err_count saturates at 255. With EN_BRANCH=0, a beq decodes as illegal=1, branch=0.
- flush asserted together with in_valid in the same cycle: the next cycle has out_valid=0, err_count unchanged, paused=0.
